// File: rtl/vga_pixel_gen_pkg.sv
// Shared VGA 640x480 timing constants, colours and types for vga_pixel_gen.
package vga_pixel_gen_pkg;

  localparam logic [9:0] H_SYNC  = 10'd96;
  localparam logic [9:0] H_BP    = 10'd48;
  localparam logic [9:0] H_DISP  = 10'd640;
  localparam logic [9:0] H_FP    = 10'd16;
  localparam logic [9:0] H_TOTAL = H_SYNC + H_BP + H_DISP + H_FP;

  localparam logic [9:0] V_SYNC  = 10'd2;
  localparam logic [9:0] V_BP    = 10'd33;
  localparam logic [9:0] V_DISP  = 10'd480;
  localparam logic [9:0] V_FP    = 10'd10;
  localparam logic [9:0] V_TOTAL = V_SYNC + V_BP + V_DISP + V_FP;

  localparam logic [9:0] H_ACT_START = H_SYNC + H_BP;
  localparam logic [9:0] H_ACT_END   = H_ACT_START + H_DISP;
  localparam logic [9:0] V_ACT_START = V_SYNC + V_BP;
  localparam logic [9:0] V_ACT_END   = V_ACT_START + V_DISP;

  localparam logic [7:0] COL_BLACK  = 8'b000_000_00;
  localparam logic [7:0] COL_GREEN  = 8'b000_111_00;
  localparam logic [7:0] COL_GROUND = 8'b000_101_00;

  typedef enum logic {StUnlocked, StLocked} lock_state_e;

  typedef enum logic [1:0] {PhSync, PhBack, PhActive, PhFront} h_phase_e;

  function automatic h_phase_e h_phase(input logic [9:0] h);
    if (h < H_SYNC)         return PhSync;
    else if (h < H_ACT_START) return PhBack;
    else if (h < H_ACT_END) return PhActive;
    else                    return PhFront;
  endfunction

endpackage

// File: rtl/player_sprite_rom.sv
// Player ship bitmap: 8 rows of 16 pixels, bit 15 is the leftmost pixel.
module player_sprite_rom (
  input  logic [2:0]  row,
  output logic [15:0] line
);

  always_comb begin
    line = 16'h0000;
    unique case (row)
      3'd0: line = 16'h0180;
      3'd1: line = 16'h03C0;
      3'd2: line = 16'h03C0;
      3'd3: line = 16'h7FFE;
      3'd4: line = 16'hFFFF;
      3'd5: line = 16'hFFFF;
      3'd6: line = 16'hFFFF;
      3'd7: line = 16'hFFFF;
      default: line = 16'h0000;
    endcase
  end

endmodule

// File: rtl/vga_pixel_gen.sv
// Rebuilds beam position from hsync/vsync edges and draws the playfield.
// Define VGA_TESTPATTERN_EN to replace the game drawing with 8 colour bars.
module vga_pixel_gen
  import vga_pixel_gen_pkg::*;
#(
  parameter int unsigned PLAYER_Y = 440,
  parameter int unsigned GROUND_Y = 470,
  parameter int unsigned SPRITE_W = 16,
  parameter int unsigned SPRITE_H = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_pixel,
  input  logic       hsync,
  input  logic       vsync,
  input  logic [9:0] player_x,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       active,
  output logic       frame_start
);

  localparam logic [9:0] PY     = 10'(PLAYER_Y);
  localparam logic [9:0] GY     = 10'(GROUND_Y);
  localparam logic [9:0] SW     = 10'(SPRITE_W);
  localparam logic [9:0] SH     = 10'(SPRITE_H);
  localparam logic [9:0] PX_MAX = H_DISP - SW;

  lock_state_e lock_q, lock_d;
  h_phase_e    h_ph;

  logic       hs_prev_q, vs_prev_q, hs_fall, vs_fall;
  logic [9:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic [9:0] px_lat_q, px_lat_d;
  logic [9:0] cur_x, cur_y;
  logic [9:0] pixel_x_q, pixel_x_d, pixel_y_q, pixel_y_d;
  logic [7:0] rgb_q, rgb_d, colour;
  logic       active_q, active_d, in_win;

  assign hs_fall     = clk_pixel & hs_prev_q & ~hsync;
  assign vs_fall     = clk_pixel & vs_prev_q & ~vsync;
  assign frame_start = vs_fall;

  // vsync edge wins over a coincident hsync edge
  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (vs_fall) begin
      hcount_d = '0;
      vcount_d = '0;
    end else if (hs_fall) begin
      hcount_d = '0;
      if (vcount_q != '1) vcount_d = vcount_q + 10'd1;
    end else if (hcount_q != '1) begin
      hcount_d = hcount_q + 10'd1;
    end
  end

  always_comb begin
    lock_d = lock_q;
    case (lock_q)
      StUnlocked: if (vs_fall) lock_d = StLocked;
      StLocked:   if (hcount_d >= H_TOTAL || vcount_d >= V_TOTAL) lock_d = StUnlocked;
      default:    lock_d = StUnlocked;
    endcase
  end

  assign px_lat_d = vs_fall ? ((player_x > PX_MAX) ? PX_MAX : player_x) : px_lat_q;

  assign h_ph   = h_phase(hcount_q);
  assign in_win = (lock_q == StLocked) && (h_ph == PhActive) &&
                  (vcount_q >= V_ACT_START) && (vcount_q < V_ACT_END);
  assign cur_x  = hcount_q - H_ACT_START;
  assign cur_y  = vcount_q - V_ACT_START;

`ifdef VGA_TESTPATTERN_EN
  logic [5:0] bar;

  assign bar    = cur_x[9:4] / 6'd5;
  assign colour = {{3{bar[2]}}, {3{bar[1]}}, {2{bar[0]}}};
`else
  logic [9:0]  sx_off, sy_off;
  logic [15:0] rom_line;
  logic        spr_hit;

  assign sx_off = cur_x - px_lat_q;
  assign sy_off = cur_y - PY;

  player_sprite_rom u_rom (
    .row  (sy_off[2:0]),
    .line (rom_line)
  );

  assign spr_hit = (cur_x >= px_lat_q) && (sx_off < SW) &&
                   (cur_y >= PY) && (sy_off < SH) &&
                   rom_line[4'd15 - sx_off[3:0]];

  always_comb begin
    colour = COL_BLACK;
    if (spr_hit)          colour = COL_GREEN;
    else if (cur_y == GY) colour = COL_GROUND;
  end
`endif

  assign active_d  = in_win;
  assign rgb_d     = in_win ? colour : COL_BLACK;
  assign pixel_x_d = in_win ? cur_x : '0;
  assign pixel_y_d = in_win ? cur_y : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q    <= StUnlocked;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      hcount_q  <= '0;
      vcount_q  <= '0;
      px_lat_q  <= '0;
      rgb_q     <= COL_BLACK;
      active_q  <= 1'b0;
      pixel_x_q <= '0;
      pixel_y_q <= '0;
    end else if (clk_pixel) begin
      lock_q    <= lock_d;
      hs_prev_q <= hsync;
      vs_prev_q <= vsync;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      px_lat_q  <= px_lat_d;
      rgb_q     <= rgb_d;
      active_q  <= active_d;
      pixel_x_q <= pixel_x_d;
      pixel_y_q <= pixel_y_d;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign active  = active_q;
  assign pixel_x = pixel_x_q;
  assign pixel_y = pixel_y_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Self-checking bench for vga_pixel_gen: synthetic sync stream, beam-position reference model.
module tb_vga_pixel_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_pixel = 1'b0;
  logic       hsync = 1'b1;
  logic       vsync = 1'b1;
  logic [9:0] player_x = '0;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic [9:0] pixel_x, pixel_y;
  logic       active, frame_start;

  int passed = 0;
  int total  = 0;
  int frame_active;

  // Reference beam state as seen by the DUT before the next strobe
  int m_h, m_v, m_px;
  bit m_lock;
  logic [15:0] rom_img [0:7];

  vga_pixel_gen dut (
    .clk         (clk),
    .rst         (rst),
    .clk_pixel   (clk_pixel),
    .hsync       (hsync),
    .vsync       (vsync),
    .player_x    (player_x),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .active      (active),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #20000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // {active, pixel_x, pixel_y, rgb} for a beam position
  function automatic logic [28:0] expect_px(input int h, input int v, input bit lk, input int px);
    int x, y;
    logic [7:0] c;
    logic [2:0] b;
    if (!lk || h < 144 || h >= 784 || v < 35 || v >= 515) return '0;
    x = h - 144;
    y = v - 35;
`ifdef VGA_TESTPATTERN_EN
    b = 3'(x / 80);
    c = {{3{b[2]}}, {3{b[1]}}, {2{b[0]}}};
`else
    b = '0;
    c = 8'h00;
    if (y == 470) c = 8'h14;
    if (x >= px && x < px + 16 && y >= 440 && y < 448 && rom_img[y - 440][15 - (x - px)])
      c = 8'h1C;
`endif
    return {1'b1, 10'(x), 10'(y), c};
  endfunction

  task automatic strobe(input bit line_start, input bit pulse, input bit vs_start,
                        input bit hs, input bit vs);
    logic [28:0] exp;
    bit exp_fs;
    exp    = expect_px(m_h, m_v, m_lock, m_px);
    exp_fs = line_start && vs_start;
    clk_pixel = 1'b1;
    hsync     = hs;
    vsync     = vs;
    @(negedge clk);
    chk("frame_start", 32'(frame_start), 32'(exp_fs));
    @(posedge clk);
    #1;
    clk_pixel = 1'b0;
    chk("pixel", 32'({active, pixel_x, pixel_y, red, green, blue}), 32'(exp));
    if (active) frame_active++;
    if (exp_fs) begin
      m_h = 0;
      m_v = 0;
      m_lock = 1'b1;
      m_px = (player_x > 10'd624) ? 624 : int'(player_x);
    end else if (line_start && pulse) begin
      m_h = 0;
      m_v++;
    end else begin
      m_h++;
    end
    if (m_h >= 800 || m_v >= 525) m_lock = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_line(input int len, input bit pulse, input bit vs_low, input bit vs_start);
    for (int h = 0; h < len; h++)
      strobe(h == 0, pulse, vs_start, pulse ? !(h < 96 && h < len - 1) : 1'b1, !vs_low);
  endtask

  task automatic run_frame(input int nlines, input bit full_set, input int chg_line,
                           input logic [9:0] chg_val);
    bit full;
    for (int v = 0; v < nlines; v++) begin
      if (v == chg_line) player_x = chg_val;
      full = (v >= 475 && v <= 482) || v == 505;
      if (full_set && (v == 35 || v == 514)) full = 1'b1;
      run_line(full ? 800 : 8, 1'b1, v < 2, v == 0);
    end
  endtask

  initial begin
    rom_img[0] = 16'h0180; rom_img[1] = 16'h03C0; rom_img[2] = 16'h03C0; rom_img[3] = 16'h7FFE;
    rom_img[4] = 16'hFFFF; rom_img[5] = 16'hFFFF; rom_img[6] = 16'hFFFF; rom_img[7] = 16'hFFFF;
    m_h = 0; m_v = 0; m_lock = 1'b0; m_px = 0; frame_active = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_active", 32'(active), 32'd0);
    chk("reset_rgb", 32'({red, green, blue}), 32'd0);
    chk("reset_pixel_x", 32'(pixel_x), 32'd0);
    chk("reset_pixel_y", 32'(pixel_y), 32'd0);
    chk("reset_frame_start", 32'(frame_start), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Syncs running but no vsync edge yet: must stay dark
    repeat (3) run_line(300, 1'b1, 1'b0, 1'b0);

    // Frame 1: sprite at 100, request moves mid-frame (must not tear)
    player_x = 10'd100;
    frame_active = 0;
    run_frame(525, 1'b1, 200, 10'd700);
    chk("frame1_active_pixels", 32'(frame_active), 32'd7040);

    // Frame 2: clamped to 624; frame 3: random position
    run_frame(525, 1'b0, 100, 10'($urandom_range(0, 1023)));
    run_frame(525, 1'b0, -1, 10'd0);

    // Missing hsync pulse drops lock mid-frame
    for (int v = 0; v < 40; v++) run_line(8, 1'b1, v < 2, v == 0);
    run_line(820, 1'b0, 1'b0, 1'b0);
    repeat (3) run_line(300, 1'b1, 1'b0, 1'b0);

    // Relock, then reset asynchronously in the middle of an active line
    for (int v = 0; v <= 35; v++) run_line(v == 35 ? 800 : 8, 1'b1, v < 2, v == 0);
    run_line(400, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_active", 32'(active), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_active", 32'(active), 32'd0);
    chk("async_reset_rgb", 32'({red, green, blue}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    m_lock = 1'b0; m_h = 0; m_v = 0; m_px = 0;
    repeat (100) strobe(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int v = 0; v <= 35; v++) run_line(v == 35 ? 800 : 8, 1'b1, v < 2, v == 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
